// File: rtl/note_table_writer.sv
// Queues note on/off events and writes them into the renderer's note table,
// draining only while vsync is active so a visible frame never sees a partial update.
module note_table_writer #(
    parameter int NOTE_W      = 6,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [NOTE_W-1:0]             ev_note,
    input  logic                          ev_on,
    input  logic                          vs,
    output logic                          wr_en,
    output logic [NOTE_W-1:0]             wr_addr,
    output logic                          wr_data,
    input  logic                          wr_ack,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [7:0]                    frame_cnt,
    output logic                          err_timeout
);
    // state | meaning
    // IDLE  | no write in flight; start one when the vsync window is open and FIFO not empty
    // ISSUE | wr_en held until wr_ack or the ack timer expires; head is popped either way

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                state_q, state_d;
    logic                  vs_m_q, vs_s_q;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [NOTE_W:0]       mem_q [FIFO_DEPTH];
    logic [NOTE_W:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [NOTE_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  err_q, err_d;
    logic                  push, pop;

    assign ev_ready    = (count_q < CNT_W'(FIFO_DEPTH));
    assign push        = ev_valid && ev_ready;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign pending     = count_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        timer_d     = timer_q;
        err_d       = err_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!vs_s_q && count_q != '0) begin
                    state_d   = ISSUE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = mem_q[rd_ptr_q][NOTE_W-1:0];
                    wr_data_d = mem_q[rd_ptr_q][NOTE_W];
                    timer_d   = '0;
                end
            end
            ISSUE: begin
                // ack wins over a simultaneous timeout
                if (wr_ack) begin
                    pop     = 1'b1;
                    wr_en_d = 1'b0;
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    pop     = 1'b1;
                    wr_en_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ev_on, ev_note};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // vs_s is about to fall: count the frame on the same edge it does
        frame_cnt_d = (vs_s_q && !vs_m_q) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            vs_m_q      <= 1'b1;
            vs_s_q      <= 1'b1;
            frame_cnt_q <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
            timer_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_m_q      <= vs;
            vs_s_q      <= vs_m_q;
            frame_cnt_q <= frame_cnt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_note_table_writer.sv
// Directed bench for note_table_writer: queueing, vsync-gated draining, backpressure,
// window closing mid-write, ack timeout and reset mid-write.
module tb_note_table_writer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic [5:0] ev_note = '0;
    logic       ev_on = 1'b0;
    logic       vs = 1'b1;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       wr_data;
    logic       wr_ack = 1'b0;
    logic [3:0] pending;
    logic [7:0] frame_cnt;
    logic       err_timeout;

    int checks = 0;
    int failures = 0;

    note_table_writer dut (
        .Clk(Clk), .Reset(Reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_note(ev_note), .ev_on(ev_on), .vs(vs), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .pending(pending), .frame_cnt(frame_cnt),
        .err_timeout(err_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; ev_valid = 1'b0; wr_ack = 1'b0; vs = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic push(input int note, input bit on);
        check_eq("push_ready", int'(ev_ready), 1);
        ev_valid = 1'b1; ev_note = 6'(note); ev_on = on;
        @(negedge Clk);
        ev_valid = 1'b0;
    endtask

    task automatic wait_wr_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wr_en) begin ok = 1'b1; break; end
            @(negedge Clk);
        end
        if (!ok) check_eq("wr_en_wait_expired", 0, 1);
    endtask

    task automatic do_write(input int addr, input int data, input int pend_after,
                            input bit close_vs);
        bit ok;
        wait_wr_en(ok);
        if (ok) begin
            check_eq("wr_addr", int'(wr_addr), addr);
            check_eq("wr_data", int'(wr_data), data);
            if (close_vs) vs = 1'b1;
            @(negedge Clk);
            check_eq("wr_en_held", int'(wr_en), 1);
            wr_ack = 1'b1;
            @(negedge Clk);
            wr_ack = 1'b0;
            check_eq("wr_en_drop", int'(wr_en), 0);
            check_eq("pending_after_write", int'(pending), pend_after);
        end
    endtask

    initial begin
        bit ok;
        bit rdy;
        int acc;
        int hi;
        int seen;

        // 1: reset state, stray ack ignored
        do_reset();
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_pending", int'(pending), 0);
        check_eq("rst_frame_cnt", int'(frame_cnt), 0);
        check_eq("rst_err", int'(err_timeout), 0);
        check_eq("rst_ev_ready", int'(ev_ready), 1);
        check_eq("rst_wr_addr", int'(wr_addr), 0);
        wr_ack = 1'b1;
        @(negedge Clk);
        wr_ack = 1'b0;
        check_eq("stray_ack_pending", int'(pending), 0);
        check_eq("stray_ack_wr_en", int'(wr_en), 0);

        // 2: three events, drained in order once the window opens
        push(5, 1'b1);
        push(12, 1'b1);
        push(40, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (wr_en) seen++;
            @(negedge Clk);
        end
        check_eq("no_write_outside_window", seen, 0);
        check_eq("pending_3", int'(pending), 3);
        vs = 1'b0;
        do_write(5, 1, 2, 1'b0);
        do_write(12, 1, 1, 1'b0);
        do_write(40, 0, 0, 1'b0);
        check_eq("t2_frame_cnt", int'(frame_cnt), 1);
        vs = 1'b1;

        // 3: backpressure at full, space reopens after first ack
        do_reset();
        acc = 0;
        ev_valid = 1'b1; ev_note = 6'd0; ev_on = 1'b0;
        for (int c = 0; c < 12; c++) begin
            rdy = ev_ready;
            @(negedge Clk);
            if (rdy) begin
                acc++;
                ev_note = 6'(acc);
                ev_on = acc[0];
            end
        end
        check_eq("full_accepted", acc, 8);
        check_eq("full_ev_ready", int'(ev_ready), 0);
        check_eq("full_pending", int'(pending), 8);
        vs = 1'b0;
        wait_wr_en(ok);
        if (ok) begin
            check_eq("t3_first_addr", int'(wr_addr), 0);
            @(negedge Clk);
            wr_ack = 1'b1;
            @(negedge Clk);
            wr_ack = 1'b0;
            check_eq("t3_pending_7", int'(pending), 7);
            check_eq("t3_ready_after_pop", int'(ev_ready), 1);
            @(negedge Clk);
            ev_valid = 1'b0;
            check_eq("t3_ninth_accepted", int'(pending), 8);
            for (int n = 1; n <= 8; n++) do_write(n, n % 2, 8 - n, 1'b0);
        end
        ev_valid = 1'b0;
        vs = 1'b1;

        // 4: window closes during second write
        do_reset();
        for (int n = 20; n < 24; n++) push(n, 1'b1);
        vs = 1'b0;
        do_write(20, 1, 3, 1'b0);
        do_write(21, 1, 2, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_en) seen++;
            @(negedge Clk);
        end
        check_eq("closed_window_no_write", seen, 0);
        check_eq("closed_window_pending", int'(pending), 2);
        vs = 1'b0;
        do_write(22, 1, 1, 1'b0);
        do_write(23, 1, 0, 1'b0);
        check_eq("t4_frame_cnt", int'(frame_cnt), 2);
        vs = 1'b1;

        // 5: ack timeout
        do_reset();
        push(7, 1'b0);
        vs = 1'b0;
        wait_wr_en(ok);
        hi = 0;
        while (wr_en && hi < 40) begin
            hi++;
            @(negedge Clk);
        end
        check_eq("timeout_high_cycles", hi, 16);
        check_eq("timeout_err", int'(err_timeout), 1);
        check_eq("timeout_pending", int'(pending), 0);
        push(9, 1'b1);
        do_write(9, 1, 0, 1'b0);
        check_eq("timeout_err_sticky", int'(err_timeout), 1);
        vs = 1'b1;

        // 6: reset mid-write discards everything
        do_reset();
        push(1, 1'b1);
        push(2, 1'b1);
        push(3, 1'b1);
        push(4, 1'b1);
        vs = 1'b0;
        wait_wr_en(ok);
        check_eq("t6_pending_before_rst", int'(pending), 4);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("t6_wr_en_after_rst", int'(wr_en), 0);
        check_eq("t6_pending_after_rst", int'(pending), 0);
        check_eq("t6_err_after_rst", int'(err_timeout), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_en) seen++;
            @(negedge Clk);
        end
        check_eq("t6_no_writes", seen, 0);
        vs = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit");
    end
endmodule
